// File: rtl/buck_pwm_sequencer_if.sv
// buck_pwm_sequencer_if: host/model-side control and status bundle of the buck PWM sequencer.
interface buck_pwm_sequencer_if #(
  parameter int model_data_width = 25,
  parameter int counter_width    = 16,
  parameter int prescaler_width  = 8
);
  logic                               enable_i;
  logic                               fault_clear_i;
  logic        [prescaler_width-1:0]  prescaler_i;
  logic        [counter_width-1:0]    pwm_period_i;
  logic        [counter_width-1:0]    duty_target_i;
  logic        [counter_width-1:0]    ramp_step_i;
  logic signed [model_data_width-1:0] inductor_current_i;
  logic signed [model_data_width-1:0] current_limit_i;
  logic                               clock_enable_o;
  logic                               pwm_o;
  logic                               period_start_o;
  logic        [counter_width-1:0]    duty_active_o;
  logic        [1:0]                  state_o;
  logic                               fault_o;
  modport master (
    output enable_i, fault_clear_i, prescaler_i, pwm_period_i, duty_target_i, ramp_step_i,
           inductor_current_i, current_limit_i,
    input  clock_enable_o, pwm_o, period_start_o, duty_active_o, state_o, fault_o
  );
  modport slave (
    input  enable_i, fault_clear_i, prescaler_i, pwm_period_i, duty_target_i, ramp_step_i,
           inductor_current_i, current_limit_i,
    output clock_enable_o, pwm_o, period_start_o, duty_active_o, state_o, fault_o
  );
endinterface

// File: rtl/buck_pwm_sequencer.sv
// buck_pwm_sequencer: model step strobe, step-aligned PWM carrier, soft-start ramp and overcurrent trip.
module buck_pwm_sequencer #(
  parameter int model_data_width = 25,
  parameter int counter_width    = 16,
  parameter int prescaler_width  = 8
) (
  input logic aclk,
  input logic resetn,
  buck_pwm_sequencer_if.slave bus_io
);
  typedef enum logic [1:0] {IDLE, RAMP, RUN, FAULT} state_t;
  localparam logic [counter_width-1:0]   C_ONE = 1;
  localparam logic [prescaler_width-1:0] P_ONE = 1;
  state_t                     state_q, state_d;
  logic [prescaler_width-1:0] presc_q, presc_d;
  logic                       ce_q, ce_d;
  logic [counter_width-1:0]   carrier_q, carrier_d, carrier_adv;
  logic [counter_width-1:0]   duty_q, duty_d, lim, ramp_val;
  logic [counter_width:0]     sum;
  logic                       pwm_q, pwm_d, period_nz, wrap, trip;
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      ce_q      <= 1'b0;
      carrier_q <= '0;
      duty_q    <= '0;
      pwm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      ce_q      <= ce_d;
      carrier_q <= carrier_d;
      duty_q    <= duty_d;
      pwm_q     <= pwm_d;
    end
  end
  // >= rather than == so a prescaler lowered below the running count recovers at once
  assign ce_d        = presc_q >= bus_io.prescaler_i;
  assign presc_d     = ce_d ? '0 : presc_q + P_ONE;
  assign period_nz   = bus_io.pwm_period_i != '0;
  assign wrap        = ce_q && period_nz && carrier_q >= bus_io.pwm_period_i - C_ONE;
  assign carrier_adv = !ce_q ? carrier_q : (wrap || !period_nz) ? '0 : carrier_q + C_ONE;
  assign lim         = (bus_io.duty_target_i < bus_io.pwm_period_i) ? bus_io.duty_target_i : bus_io.pwm_period_i;
  assign sum         = {1'b0, duty_q} + {1'b0, bus_io.ramp_step_i};
  assign ramp_val    = (bus_io.ramp_step_i == '0 || sum >= {1'b0, lim}) ? lim : sum[counter_width-1:0];
  assign trip        = bus_io.inductor_current_i > bus_io.current_limit_i;
  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    carrier_d = carrier_adv;
    pwm_d     = pwm_q;
    case (state_q)
      IDLE: begin
        duty_d = '0;
        pwm_d  = 1'b0;
        if (bus_io.enable_i) begin
          state_d   = RAMP;
          carrier_d = '0;
        end
      end
      RAMP, RUN: begin
        if (trip || !bus_io.enable_i) begin
          state_d = trip ? FAULT : IDLE;
          duty_d  = '0;
          pwm_d   = 1'b0;
        end else begin
          if (wrap) duty_d = (state_q == RAMP) ? ramp_val : lim;
          if (wrap && state_q == RAMP && ramp_val == lim) state_d = RUN;
          if (ce_q) pwm_d = period_nz && carrier_adv < duty_d;
        end
      end
      default: begin
        duty_d = '0;
        pwm_d  = 1'b0;
        if (bus_io.fault_clear_i && !bus_io.enable_i) state_d = IDLE;
      end
    endcase
  end
  assign bus_io.clock_enable_o = ce_q;
  assign bus_io.pwm_o          = pwm_q;
  assign bus_io.period_start_o = wrap;
  assign bus_io.duty_active_o  = duty_q;
  assign bus_io.state_o        = state_q;
  assign bus_io.fault_o        = state_q == FAULT;
endmodule

// File: tb/tb_buck_pwm_sequencer.sv
// tb_buck_pwm_sequencer: scenario tasks with a queue scoreboard of expected strobe/duty/pwm results.
module tb_buck_pwm_sequencer;
  logic aclk = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_q[$];
  int   st_q[$];
  buck_pwm_sequencer_if #(.model_data_width(25), .counter_width(16), .prescaler_width(8)) bus ();
  buck_pwm_sequencer #(.model_data_width(25), .counter_width(16), .prescaler_width(8)) dut (
    .aclk(aclk), .resetn(resetn), .bus_io(bus)
  );
  always #5 aclk = ~aclk;
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask
  task automatic wait_wrap(string tag);
    int c;
    c = 0;
    do begin
      tick();
      c++;
    end while (!bus.period_start_o && c < 300);
    if (!bus.period_start_o) begin
      n_cmp++; n_err++;
      $display("FAIL %s wrap_timeout: no period_start within %0d cycles", tag, c);
    end
  endtask
  task automatic test_reset;
    int e, highs;
    bus.enable_i = 0; bus.fault_clear_i = 0; bus.prescaler_i = 3;
    bus.pwm_period_i = 10; bus.duty_target_i = 6; bus.ramp_step_i = 2;
    bus.inductor_current_i = 0; bus.current_limit_i = 25'sd1000;
    resetn = 0;
    tick(3);
    n_cmp++; if ({bus.clock_enable_o, bus.pwm_o, bus.period_start_o, bus.fault_o} !== 4'b0) begin
      n_err++; $display("FAIL reset_flags: got %b expected 0000",
        {bus.clock_enable_o, bus.pwm_o, bus.period_start_o, bus.fault_o}); end
    n_cmp++; if (bus.duty_active_o !== 16'd0) begin n_err++; $display("FAIL reset_duty: got %0d expected 0", bus.duty_active_o); end
    n_cmp++; if (bus.state_o !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", bus.state_o); end
    exp_q = {4, 8, 12};
    highs = 0;
    resetn = 1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      highs += int'(bus.pwm_o);
      if (bus.clock_enable_o) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL strobe_extra: strobe at cycle %0d expected none", c);
        end else begin
          e = exp_q.pop_front();
          if (c !== e) begin n_err++; $display("FAIL strobe_cycle: got %0d expected %0d", c, e); end
        end
      end
    end
    if (exp_q.size() != 0) begin n_cmp++; n_err++; $display("FAIL strobe_missing: %0d strobes missing", exp_q.size()); end
    n_cmp++; if (highs !== 0) begin n_err++; $display("FAIL idle_pwm: got %0d high cycles expected 0", highs); end
  endtask
  task automatic test_ramp;
    int e, s, cnt;
    logic p;
    bus.prescaler_i = 0;
    tick(4);
    bus.enable_i = 1;
    tick();
    n_cmp++; if (bus.state_o !== 2'd1) begin n_err++; $display("FAIL ramp_enter: state got %0d expected 1", bus.state_o); end
    exp_q = {2, 4, 6};
    st_q  = {1, 1, 2};
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      p = bus.period_start_o;
      tick();
      if (p) begin
        e = exp_q.pop_front();
        s = st_q.pop_front();
        n_cmp++; if (bus.duty_active_o !== 16'(e)) begin n_err++; $display("FAIL ramp_duty: got %0d expected %0d", bus.duty_active_o, e); end
        n_cmp++; if (bus.state_o !== 2'(s)) begin n_err++; $display("FAIL ramp_state: got %0d expected %0d", bus.state_o, s); end
      end
    end
    if (exp_q.size() != 0) begin n_cmp++; n_err++; $display("FAIL ramp_timeout: %0d wraps missing", exp_q.size()); end
    wait_wrap("run");
    exp_q = {6, 6};
    for (int w = 0; w < 2; w++) begin
      cnt = 0;
      repeat (10) begin tick(); cnt += int'(bus.pwm_o); end
      e = exp_q.pop_front();
      n_cmp++; if (cnt !== e) begin n_err++; $display("FAIL run_pwm_count: got %0d expected %0d", cnt, e); end
    end
  endtask
  task automatic test_target_change;
    int e, cnt;
    wait_wrap("target");
    exp_q = {6, 3};
    for (int w = 0; w < 2; w++) begin
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        cnt += int'(bus.pwm_o);
        if (w == 0 && i == 3) bus.duty_target_i = 3;
        if (w == 0 && i == 5) begin
          n_cmp++; if (bus.duty_active_o !== 16'd6) begin n_err++; $display("FAIL target_hold: got %0d expected 6", bus.duty_active_o); end
        end
        if (w == 1 && i == 0) begin
          n_cmp++; if (bus.duty_active_o !== 16'd3) begin n_err++; $display("FAIL target_apply: got %0d expected 3", bus.duty_active_o); end
        end
      end
      e = exp_q.pop_front();
      n_cmp++; if (cnt !== e) begin n_err++; $display("FAIL target_pwm_count: got %0d expected %0d", cnt, e); end
    end
  endtask
  task automatic test_fault;
    bus.inductor_current_i = 25'sd1000;
    tick();
    n_cmp++; if ({bus.state_o, bus.pwm_o} !== 3'b101) begin n_err++; $display("FAIL trip_equal: state/pwm got %b expected 101", {bus.state_o, bus.pwm_o}); end
    bus.inductor_current_i = 25'sd1001;
    tick();
    n_cmp++; if ({bus.state_o, bus.fault_o, bus.pwm_o} !== 4'b1110) begin
      n_err++; $display("FAIL trip: state/fault/pwm got %b expected 1110", {bus.state_o, bus.fault_o, bus.pwm_o}); end
    n_cmp++; if (bus.duty_active_o !== 16'd0) begin n_err++; $display("FAIL trip_duty: got %0d expected 0", bus.duty_active_o); end
    bus.fault_clear_i = 1;
    tick(2);
    n_cmp++; if (bus.state_o !== 2'd3) begin n_err++; $display("FAIL clear_ignored: state got %0d expected 3", bus.state_o); end
    bus.enable_i = 0;
    tick();
    n_cmp++; if ({bus.state_o, bus.fault_o} !== 3'b000) begin n_err++; $display("FAIL clear: state/fault got %b expected 000", {bus.state_o, bus.fault_o}); end
    bus.fault_clear_i = 0;
    bus.current_limit_i = -25'sd10;
    bus.inductor_current_i = -25'sd20;
    bus.enable_i = 1;
    tick(3);
    n_cmp++; if (bus.state_o !== 2'd1) begin n_err++; $display("FAIL signed_below: state got %0d expected 1", bus.state_o); end
    bus.inductor_current_i = -25'sd9;
    tick();
    n_cmp++; if (bus.state_o !== 2'd3) begin n_err++; $display("FAIL signed_trip: state got %0d expected 3", bus.state_o); end
    bus.enable_i = 0; bus.fault_clear_i = 1;
    tick();
    bus.fault_clear_i = 0; bus.inductor_current_i = 0; bus.current_limit_i = 25'sd1000;
    n_cmp++; if (bus.state_o !== 2'd0) begin n_err++; $display("FAIL signed_clear: state got %0d expected 0", bus.state_o); end
  endtask
  task automatic test_clamp;
    int e, cnt, ps;
    bus.duty_target_i = 15; bus.ramp_step_i = 0; bus.pwm_period_i = 10;
    bus.enable_i = 1;
    tick();
    wait_wrap("clamp");
    tick();
    n_cmp++; if (bus.duty_active_o !== 16'd10) begin n_err++; $display("FAIL clamp_duty: got %0d expected 10", bus.duty_active_o); end
    n_cmp++; if (bus.state_o !== 2'd2) begin n_err++; $display("FAIL clamp_state: got %0d expected 2", bus.state_o); end
    exp_q = {20, 0, 0};
    cnt = 0;
    repeat (20) begin tick(); cnt += int'(bus.pwm_o); end
    e = exp_q.pop_front();
    n_cmp++; if (cnt !== e) begin n_err++; $display("FAIL clamp_pwm: got %0d expected %0d", cnt, e); end
    bus.pwm_period_i = 0;
    tick(2);
    cnt = 0; ps = 0;
    repeat (10) begin tick(); cnt += int'(bus.pwm_o); ps += int'(bus.period_start_o); end
    e = exp_q.pop_front();
    n_cmp++; if (cnt !== e) begin n_err++; $display("FAIL zero_period_pwm: got %0d expected %0d", cnt, e); end
    e = exp_q.pop_front();
    n_cmp++; if (ps !== e) begin n_err++; $display("FAIL zero_period_wrap: got %0d expected %0d", ps, e); end
    bus.enable_i = 0;
    tick();
  endtask
  task automatic test_reset_mid_ramp;
    int ps_q[$];
    int e;
    bit seen_ce, seen_ps;
    bus.prescaler_i = 3; bus.pwm_period_i = 10; bus.duty_target_i = 6; bus.ramp_step_i = 2;
    bus.enable_i = 1;
    tick(50);
    n_cmp++; if (bus.state_o !== 2'd1) begin n_err++; $display("FAIL midramp_state: got %0d expected 1", bus.state_o); end
    resetn = 0; bus.enable_i = 0;
    tick();
    n_cmp++; if ({bus.clock_enable_o, bus.pwm_o, bus.period_start_o, bus.fault_o, bus.state_o} !== 6'b0) begin
      n_err++; $display("FAIL midramp_reset_flags: got %b expected 000000",
        {bus.clock_enable_o, bus.pwm_o, bus.period_start_o, bus.fault_o, bus.state_o}); end
    n_cmp++; if (bus.duty_active_o !== 16'd0) begin n_err++; $display("FAIL midramp_reset_duty: got %0d expected 0", bus.duty_active_o); end
    tick();
    exp_q = {4};
    ps_q  = {40};
    seen_ce = 0; seen_ps = 0;
    resetn = 1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (bus.clock_enable_o && !seen_ce) begin
        seen_ce = 1; e = exp_q.pop_front();
        n_cmp++; if (c !== e) begin n_err++; $display("FAIL restart_strobe: got cycle %0d expected %0d", c, e); end
      end
      if (bus.period_start_o && !seen_ps) begin
        seen_ps = 1; e = ps_q.pop_front();
        n_cmp++; if (c !== e) begin n_err++; $display("FAIL restart_carrier: got cycle %0d expected %0d", c, e); end
      end
    end
    if (exp_q.size() + ps_q.size() != 0) begin
      n_cmp++; n_err++; $display("FAIL restart_timeout: %0d events missing", exp_q.size() + ps_q.size()); end
  endtask
  initial begin
    test_reset();
    test_ramp();
    test_target_change();
    test_fault();
    test_clamp();
    test_reset_mid_ramp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
